// File: rtl/mem_responder.sv
// Single-port memory responder shared by a fetch port (i_*) and a data port (d_*).
// Accepts one request at a time, arbitrates fetch against data, and answers after
// a fixed LATENCY cycles with a one-cycle rvalid strobe on the granted port.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   i_req, i_addr               fetch read request (held until i_gnt)
//   i_gnt, i_rvalid, i_rdata    fetch grant, response strobe, read data
//   d_req, d_we, d_addr, d_wdata  data request (held until d_gnt)
//   d_gnt, d_rvalid, d_rdata    data grant, response strobe (read or write ack), read data
//   busy                        high while a request is in flight
//
// state     | meaning
// ST_IDLE   | no request in flight; grant is raised combinationally
// ST_ACCESS | request latched, counting down LATENCY-1 cycles
// ST_RESP   | response cycle; rvalid high on the granted port
module mem_responder #(
   parameter int DATA_W  = 16,
   parameter int MEM_AW  = 10,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic [15:0]       i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [15:0]       d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              busy
);

   localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

   state_t              state, state_nxt;
   logic [3:0]          cnt;
   logic                fetch_denied;
   logic                sel_i, sel_d;
   logic                enter_resp;

   logic                lat_is_d, lat_we;
   logic [MEM_AW-1:0]   lat_addr;
   logic [DATA_W-1:0]   lat_wdata;

   logic                acc_is_d, acc_we;
   logic [MEM_AW-1:0]   acc_addr;
   logic [DATA_W-1:0]   acc_wdata;

   logic [DATA_W-1:0]   mem [2**MEM_AW];

   // Upper address bits alias onto the storage and are intentionally dropped.
   logic                unused_addr_hi;
   assign unused_addr_hi = ^{i_addr[15:MEM_AW], d_addr[15:MEM_AW]};

   always_comb begin
      sel_i     = 1'b0;
      sel_d     = 1'b0;
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            // Data wins, unless fetch lost the previous contended grant.
            if (i_req && (!d_req || fetch_denied)) begin
               sel_i = 1'b1;
            end else if (d_req) begin
               sel_d = 1'b1;
            end
            if (sel_i || sel_d) begin
               state_nxt = (LATENCY == 1) ? ST_RESP : ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (cnt == 4'd1) begin
               state_nxt = ST_RESP;
            end
         end
         ST_RESP:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   assign i_gnt      = sel_i & rst_n;
   assign d_gnt      = sel_d & rst_n;
   assign enter_resp = rst_n && (state_nxt == ST_RESP);
   assign busy       = (state != ST_IDLE);

   // With LATENCY=1 the RESP edge is also the grant edge, so the access uses the
   // live inputs; otherwise it uses the values latched at the grant.
   always_comb begin
      if (state == ST_IDLE) begin
         acc_is_d  = sel_d;
         acc_we    = sel_d & d_we;
         acc_addr  = sel_d ? d_addr[MEM_AW-1:0] : i_addr[MEM_AW-1:0];
         acc_wdata = d_wdata;
      end else begin
         acc_is_d  = lat_is_d;
         acc_we    = lat_we;
         acc_addr  = lat_addr;
         acc_wdata = lat_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         cnt          <= 4'd0;
         fetch_denied <= 1'b0;
         i_rvalid     <= 1'b0;
         d_rvalid     <= 1'b0;
         i_rdata      <= '0;
         d_rdata      <= '0;
      end else begin
         state    <= state_nxt;
         i_rvalid <= enter_resp & ~acc_is_d;
         d_rvalid <= enter_resp &  acc_is_d;

         if (i_gnt) begin
            fetch_denied <= 1'b0;
         end else if (d_gnt) begin
            fetch_denied <= i_req;
         end

         if (i_gnt || d_gnt) begin
            cnt       <= CNT_LOAD;
            lat_is_d  <= acc_is_d;
            lat_we    <= acc_we;
            lat_addr  <= acc_addr;
            lat_wdata <= acc_wdata;
         end else if (state == ST_ACCESS && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end

         if (enter_resp && !acc_we) begin
            if (acc_is_d) begin
               d_rdata <= mem[acc_addr];
            end else begin
               i_rdata <= mem[acc_addr];
            end
         end
      end
   end

   // Storage has no reset; a write lands on the edge entering RESP.
   always_ff @(posedge clk) begin
      if (enter_resp && acc_we) begin
         mem[acc_addr] <= acc_wdata;
      end
   end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the data word width.
REQ-002 SHALL have parameter MEM_AW, default 10, meaning the storage index width (2^MEM_AW words).
REQ-003 SHALL have parameter LATENCY, default 2, meaning the cycles from grant to response; the legal range is 1..15.
REQ-004 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous, active-low.
REQ-006 SHALL have port i_req  input  1  fetch read request, held until granted.
REQ-007 SHALL have port i_addr  input  16  fetch word address.
REQ-008 SHALL have port i_gnt  output  1  fetch request accepted this cycle.
REQ-009 SHALL have port i_rvalid  output  1  one-cycle fetch response strobe.
REQ-010 SHALL have port i_rdata  output  DATA_W  fetch read data.
REQ-011 SHALL have port d_req  input  1  data request, held until granted.
REQ-012 SHALL have port d_we  input  1  data request is a write (1) or a read (0).
REQ-013 SHALL have port d_addr  input  16  data word address.
REQ-014 SHALL have port d_wdata  input  DATA_W  data write value.
REQ-015 SHALL have port d_gnt  output  1  data request accepted this cycle.
REQ-016 SHALL have port d_rvalid  output  1  one-cycle data response strobe (read data or write ack).
REQ-017 SHALL have port d_rdata  output  DATA_W  data read data.
REQ-018 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-019 SHALL implement the FSM states IDLE, ACCESS and RESP; the block serves one request at a time.
REQ-020 SHALL, in IDLE, raise i_gnt or d_gnt combinationally in the same cycle a request is selected, never both.
REQ-021 SHALL never assert i_gnt or d_gnt outside IDLE.
REQ-022 SHALL, on a grant, latch the port id, address, we and wdata at that edge; later input changes have no effect.
REQ-023 SHALL apply arbitration: d_req wins over i_req, except when i_req was denied at the previous grant; in that case i_req wins (alternation under contention).
REQ-024 SHALL clear the "fetch denied" flag whenever a fetch is granted.
REQ-025 SHALL, after a grant at cycle T, spend LATENCY-1 cycles in ACCESS, then one cycle in RESP (cycle T+LATENCY), then return to IDLE; the next grant is possible no earlier than T+LATENCY+1.
REQ-026 SHALL, with LATENCY=1, go IDLE->RESP directly with no ACCESS cycles.
REQ-027 SHALL count ACCESS cycles with a 4-bit down-counter loaded with LATENCY-1 at the grant.
REQ-028 SHALL assert exactly one strobe, on the granted port's rvalid, for the single RESP cycle.
REQ-029 SHALL, on a read, present the word at addr[MEM_AW-1:0] on that port's rdata during RESP, and hold it until that port's next read response.
REQ-030 SHALL commit a write to storage on the edge entering RESP; d_rdata is unchanged by writes.
REQ-031 SHALL make a read granted after a write's RESP return the written value (no stale data).
REQ-032 SHALL ignore address bits 15:MEM_AW (aliasing, no error).
REQ-033 SHALL keep busy high in ACCESS and RESP and low in IDLE.

Reset
REQ-034 SHALL, when rst_n=0 at a rising edge, set the FSM to IDLE, the counter and denied flag to 0, and i_rvalid, d_rvalid, i_rdata and d_rdata to 0.
REQ-035 SHALL hold i_gnt and d_gnt low during any cycle with rst_n=0.
REQ-036 SHALL, on reset during ACCESS, abandon the request: no rvalid and no storage write; a write already committed in RESP remains.
REQ-037 SHALL not initialise storage contents on reset.

Verification
REQ-038 Write then read, LATENCY=2: d write addr 0x0005 data 0xBEEF granted at T -> d_rvalid at T+2 only, busy T+1..T+2; d read 0x0005 granted T+3 -> d_rvalid T+5, d_rdata=0xBEEF.
REQ-039 Contention: i_req and d_req both held high from IDLE -> grant order d, i, d, i; each i_rvalid/d_rvalid arrives LATENCY cycles after its grant.
REQ-040 Aliasing, MEM_AW=10: write 0x1234 to 0x0403, fetch from 0x0003 -> i_rdata=0x1234.
REQ-041 Reset mid-operation: write 0xAAAA to 0x0010 granted, rst_n=0 at T+1 with LATENCY=3 -> no d_rvalid, busy=0 after the edge, location 0x0010 unchanged on readback.
REQ-042 LATENCY=1: fetch granted at T -> i_rvalid at T+1; a request held continuously is granted again at T+2.
REQ-043 Held inputs: change d_addr and d_wdata after the grant -> the response and write use the latched values.
